// File: rtl/parser_packet_scheduler.sv
// Parser packet scheduler: captures header beats, runs one TCAM lookup,
// then replays and forwards the packet on a hit or drops it otherwise.
// Ports: clk/rst_n; s_axis_* in handshake; state/count to the header buffer;
// data_sel output mux; tcam_req/valid/match/dest; m_axis_* out; drop_count.
module parser_packet_scheduler #(
    parameter int AXIS_DATA_WIDTH   = 64,
    parameter int AXIS_KEEP_WIDTH   = AXIS_DATA_WIDTH/8,
    parameter int AXIS_DEST_WIDTH   = 2,
    parameter int BUFFER_DATA_WIDTH = 192,
    parameter int BUFFER_BEATS      = BUFFER_DATA_WIDTH/AXIS_DATA_WIDTH,
    parameter int COUNTER_WIDTH     = $clog2(BUFFER_BEATS+1),
    parameter int STATE_WIDTH       = 3,
    parameter int LOOKUP_TIMEOUT    = 16,
    parameter int DROP_CNT_WIDTH    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    output logic [STATE_WIDTH-1:0]     state,
    output logic [COUNTER_WIDTH-1:0]   count,
    output logic                       data_sel,
    output logic                       tcam_req,
    input  logic                       tcam_valid,
    input  logic                       tcam_match,
    input  logic [AXIS_DEST_WIDTH-1:0] tcam_dest,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [AXIS_DEST_WIDTH-1:0] m_axis_tdest,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count
);

    localparam logic [STATE_WIDTH-1:0] IDLE               = STATE_WIDTH'(0);
    localparam logic [STATE_WIDTH-1:0] PARSE_DATA         = STATE_WIDTH'(1);
    localparam logic [STATE_WIDTH-1:0] CONTROL            = STATE_WIDTH'(2);
    localparam logic [STATE_WIDTH-1:0] SEND_ANALYSED_DATA = STATE_WIDTH'(3);
    localparam logic [STATE_WIDTH-1:0] SEND_REMAIN        = STATE_WIDTH'(4);
    localparam logic [STATE_WIDTH-1:0] DROP               = STATE_WIDTH'(5);

    localparam int TIMER_W = $clog2(LOOKUP_TIMEOUT+1);
    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(BUFFER_BEATS-1);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(LOOKUP_TIMEOUT-1);

    logic [COUNTER_WIDTH-1:0]   cap_beats;
    logic                       last_seen;
    logic [AXIS_KEEP_WIDTH-1:0] last_keep;
    logic [TIMER_W-1:0]         timer;

    logic s_fire;
    logic m_fire;
    logic final_buf;

    assign s_fire    = s_axis_tvalid && s_axis_tready;
    assign m_fire    = m_axis_tvalid && m_axis_tready;
    assign final_buf = (count == cap_beats - COUNTER_WIDTH'(1));

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        data_sel      = 1'b0;
        tcam_req      = 1'b0;
        unique case (1'b1)
            (state == PARSE_DATA): s_axis_tready = 1'b1;
            // timer is zero only on the first CONTROL cycle
            (state == CONTROL): tcam_req = (timer == '0);
            (state == SEND_ANALYSED_DATA): begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = last_seen && final_buf;
                m_axis_tkeep  = (last_seen && final_buf) ? last_keep : '1;
            end
            (state == SEND_REMAIN): begin
                data_sel      = 1'b1;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tkeep  = s_axis_tkeep;
            end
            // a packet that ended inside the capture window has no tail to flush
            (state == DROP): s_axis_tready = !last_seen;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            cap_beats    <= '0;
            last_seen    <= 1'b0;
            last_keep    <= '0;
            timer        <= '0;
            m_axis_tdest <= '0;
            drop_count   <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (s_axis_tvalid) state <= PARSE_DATA;
                end
                (state == PARSE_DATA): begin
                    if (s_fire) begin
                        last_seen <= s_axis_tlast;
                        last_keep <= s_axis_tkeep;
                        cap_beats <= count + COUNTER_WIDTH'(1);
                        if (s_axis_tlast || count == LAST_IDX) begin
                            state <= CONTROL;
                            count <= '0;
                            timer <= '0;
                        end else begin
                            count <= count + COUNTER_WIDTH'(1);
                        end
                    end
                end
                (state == CONTROL): begin
                    timer <= timer + TIMER_W'(1);
                    if (tcam_valid && tcam_match) begin
                        m_axis_tdest <= tcam_dest;
                        state        <= SEND_ANALYSED_DATA;
                    end else if (tcam_valid || timer == TMO_LAST) begin
                        state <= DROP;
                        if (drop_count != '1)
                            drop_count <= drop_count + DROP_CNT_WIDTH'(1);
                    end
                end
                (state == SEND_ANALYSED_DATA): begin
                    if (m_fire) begin
                        if (final_buf) begin
                            count <= '0;
                            state <= last_seen ? IDLE : SEND_REMAIN;
                        end else begin
                            count <= count + COUNTER_WIDTH'(1);
                        end
                    end
                end
                (state == SEND_REMAIN): begin
                    if (s_fire && s_axis_tlast) state <= IDLE;
                end
                (state == DROP): begin
                    if (last_seen || (s_fire && s_axis_tlast)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
